// File: rtl/if_pc_vec_ctrl_if.sv
// Bus bundle between the IF-stage PC/vector controller and its surrounding pipeline.
interface if_pc_vec_ctrl_if #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_IRQ     = 4,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0]   if_npc;
    logic               pc_write;
    logic [NUM_IRQ-1:0] irq_req;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               int_enable;
    logic               int_restore;
    logic [WIDTH-1:0]   if_pc_out;
    logic               int_ack;
    logic [ID_W-1:0]    int_ack_id;
    logic               int_active;
    logic [DEPTH_W-1:0] int_depth;
    logic               restore_err;

    modport master (
        output if_npc, pc_write, irq_req, irq_mask, int_enable, int_restore,
        input  if_pc_out, int_ack, int_ack_id, int_active, int_depth, restore_err
    );

    modport slave (
        input  if_npc, pc_write, irq_req, irq_mask, int_enable, int_restore,
        output if_pc_out, int_ack, int_ack_id, int_active, int_depth, restore_err
    );
endinterface

// File: rtl/if_pc_vec_ctrl.sv
// Fetch PC register with prioritised vectored interrupts and a nested save/restore stack.
module if_pc_vec_ctrl #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned      NUM_IRQ     = 4,
    parameter logic [WIDTH-1:0] VEC_BASE    = WIDTH'(32'h0000_0A78),
    parameter logic [WIDTH-1:0] VEC_STRIDE  = WIDTH'(32'h0000_0010),
    parameter int unsigned      STACK_DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    if_pc_vec_ctrl_if.slave bus
);
    localparam int unsigned ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int unsigned LVL_W   = $clog2(NUM_IRQ + 1);
    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [WIDTH-1:0]   pc;
    logic [LVL_W-1:0]   cur_level;
    logic [DEPTH_W-1:0] sp;
    logic               int_ack;
    logic [ID_W-1:0]    int_ack_id;
    logic               restore_err;

    logic [WIDTH-1:0]   pc_stack  [STACK_DEPTH];
    logic [LVL_W-1:0]   lvl_stack [STACK_DEPTH];

    logic [NUM_IRQ-1:0] elig_c;
    logic               any_elig_c;
    logic [ID_W-1:0]    winner_c;
    logic               pop_c;
    logic               push_c;
    logic [IDX_W-1:0]   push_idx_c;
    logic [IDX_W-1:0]   pop_idx_c;
    logic [WIDTH-1:0]   vec_pc_c;

    // Eligibility and lowest-index winner; only strictly higher priority than the active level qualifies
    always_comb begin
        elig_c     = '0;
        any_elig_c = 1'b0;
        winner_c   = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            elig_c[i] = bus.irq_req[i] & bus.irq_mask[i] & bus.int_enable
                        & (LVL_W'(i) < cur_level);
        end
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (elig_c[i]) begin
                winner_c   = ID_W'(i);
                any_elig_c = 1'b1;
            end
        end
    end

    // A restore strobe always wins the cycle, so any concurrent take is deferred
    always_comb begin
        pop_c      = bus.int_restore & (sp != '0);
        push_c     = ~bus.int_restore & any_elig_c & (sp < DEPTH_W'(STACK_DEPTH));
        push_idx_c = IDX_W'(sp);
        pop_idx_c  = IDX_W'(sp - DEPTH_W'(1));
        vec_pc_c   = VEC_BASE + VEC_STRIDE * WIDTH'(winner_c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            cur_level   <= LVL_W'(NUM_IRQ);
            sp          <= '0;
            int_ack     <= 1'b0;
            int_ack_id  <= '0;
            restore_err <= 1'b0;
        end else begin
            int_ack <= 1'b0;
            if (pop_c) begin
                pc        <= pc_stack[pop_idx_c];
                cur_level <= lvl_stack[pop_idx_c];
                sp        <= sp - DEPTH_W'(1);
            end else if (bus.int_restore) begin
                restore_err <= 1'b1;
            end else if (push_c) begin
                pc         <= vec_pc_c;
                cur_level  <= LVL_W'(winner_c);
                sp         <= sp + DEPTH_W'(1);
                int_ack    <= 1'b1;
                int_ack_id <= winner_c;
            end else if (bus.pc_write) begin
                pc <= bus.if_npc;
            end
        end
    end

    // Save stack payload needs no reset; entries above sp are never read
    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_stack[push_idx_c]  <= pc;
            lvl_stack[push_idx_c] <= cur_level;
        end
    end

    assign bus.if_pc_out   = pc;
    assign bus.int_ack     = int_ack;
    assign bus.int_ack_id  = int_ack_id;
    assign bus.int_active  = (sp != '0);
    assign bus.int_depth   = sp;
    assign bus.restore_err = restore_err;
endmodule

// File: doc/if_pc_vec_ctrl.md
Name: if_pc_vec_ctrl

Overview:
- Parametrised successor to the IF-stage PC register.
- Holds the fetch PC and advances it from the next-PC bus under stall control.
- Adds multi-source prioritised interrupts with per-source vector addresses and a nested save/restore stack.
- Sits at the front of the pipeline, feeding the instruction memory address and IF/ID.

Parameters:
- WIDTH, 32, PC and address width.
- RESET_PC, 32'h00000000, PC value after reset.
- NUM_IRQ, 4, number of interrupt sources; index 0 is highest priority.
- VEC_BASE, 32'h00000A78, vector address of source 0.
- VEC_STRIDE, 32'h00000010, address distance between consecutive source vectors.
- STACK_DEPTH, 4, maximum interrupt nesting depth (entries in the save stack).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous reset, active-low (asserted at 0).
- if_npc  input  WIDTH  next PC from branch/jump/PC+4 selection.
- pc_write  input  1  1 = load if_npc this cycle; 0 = stall (hold PC).
- irq_req  input  NUM_IRQ  level-sensitive interrupt requests.
- irq_mask  input  NUM_IRQ  per-source enable; 1 = enabled.
- int_enable  input  1  global interrupt enable.
- int_restore  input  1  return-from-interrupt strobe (ERET decoded).
- if_pc_out  output  WIDTH  current fetch PC.
- int_ack  output  1  one-cycle pulse; an interrupt was taken on the previous edge.
- int_ack_id  output  $clog2(NUM_IRQ)  source index of the last taken interrupt.
- int_active  output  1  1 while at least one interrupt is in service.
- int_depth  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- restore_err  output  1  sticky; set when int_restore arrives with an empty stack.

Behaviour:
- Reset (reset=0, asynchronous), all values:
  - pc = RESET_PC
  - stack pointer sp = 0
  - cur_level = NUM_IRQ (idle, no interrupt in service)
  - int_ack = 0, int_ack_id = 0, restore_err = 0
  - stack contents don't-care
- Reset mid-service discards all nesting state.
- Derived values:
  - int_active = (sp != 0)
  - int_depth = sp
  - if_pc_out = pc (combinational from the register, zero latency)
- Eligibility: source i is eligible when irq_req[i] & irq_mask[i] & int_enable & (i < cur_level).
- Winner: the lowest eligible index. take = any eligible & (sp < STACK_DEPTH).
- Per rising edge, exactly one action, in priority order:
  1. int_restore=1 and sp>0: pop.
     - {pc, cur_level} <= stack[sp-1]
     - sp <= sp-1
     - A concurrent take is deferred; it re-evaluates next cycle against the restored level.
  2. int_restore=1 and sp==0: restore_err <= 1; pc and level unchanged; no take this cycle.
  3. take: push and vector.
     - stack[sp] <= {pc, cur_level}
     - sp <= sp+1
     - cur_level <= winner
     - pc <= VEC_BASE + winner*VEC_STRIDE (WIDTH-bit, modulo 2^WIDTH)
     - Saved pc is the un-executed current PC; pc_write is ignored this cycle.
  4. pc_write=1: pc <= if_npc.
  5. Otherwise: hold.
- int_ack is registered: 1 on the cycle after a push, otherwise 0. int_ack_id latches the winner on push and holds until the next push.
- Stack full (sp==STACK_DEPTH): further requests stay pending, with no loss or error, until a pop frees an entry.
- Equal or lower priority than the active level: never preempts, even with free stack space.
- Requests are level-sensitive. The source must drop irq_req before int_restore, or it is re-taken immediately after the pop.
- restore_err clears only on reset.

Test Plan:
1. Reset/stall: release reset, pc_write=1 with if_npc=4,8,C, then pc_write=0 for 2 cycles, then if_npc=10 with pc_write=1 -> if_pc_out = 0,4,8,C,C,C,10; int_active=0.
2. Single IRQ: pc=0x20, irq_req=4'b0100, mask=F, int_enable=1 -> next pc=0xA98, int_ack pulse with id=2, depth=1. Drop req, int_restore -> pc=0x20, depth=0.
3. Priority/nesting: pc=0x40, req[3] taken -> pc=0xAA8. At pc=0xAB0 assert req[1] -> pc=0xA88, depth=2. Assert req[2] during service of 1 -> no take. Two restores -> pc 0xAB0 then 0x40.
4. Simultaneous: req=4'b1010 same cycle -> source 1 wins (pc=0xA88). int_restore together with new req[0] in one cycle -> pop happens, take occurs on the following edge.
5. Overflow/masking: STACK_DEPTH=2, sources 3,2,1 asserted in sequence -> third stays pending with depth=2 until a restore, then taken. Mask bit 0 or int_enable=0 -> req[0] never taken.
6. Underflow/reset: int_restore with depth=0 -> restore_err=1, pc unchanged. Assert reset mid-service (depth=2) -> pc=0, depth=0, restore_err=0 immediately without a clock edge.
